led_byte_sequencer: RTL



---
 rtl/led_seq_pkg.sv | 18 +
 rtl/word_byte_select.sv | 37 +++
 rtl/led_byte_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and width helpers for the LED byte sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam logic [7:0] DEFAULT_IDLE_PATTERN = 8'hAA;

    // Index width for a counter over `count` values, never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/word_byte_select.sv
// Combinational pick of one display byte (0 = MSB byte) out of a packed multi-word bus.
module word_byte_select
    import led_seq_pkg::*;
#(
    parameter int NUM_WORDS = 2,
    parameter int WORD_W    = 128,
    parameter int WI_W      = idx_width(NUM_WORDS),
    parameter int BI_W      = idx_width(WORD_W / 8)
) (
    input  logic [NUM_WORDS*WORD_W-1:0] i_words,
    input  logic [WI_W-1:0]             i_word_idx,
    input  logic [BI_W-1:0]             i_byte_idx,
    output logic [7:0]                  o_byte
);

    localparam int BYTES = WORD_W / 8;
    localparam int TOTAL = NUM_WORDS * BYTES;

    logic [7:0] w_bytes [TOTAL];
    int         w_flat;

    // Flat byte table in display order: word 0 byte 0 first.
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_bytes
        assign w_bytes[gi] = i_words[(gi / BYTES) * WORD_W + WORD_W - 8 * (gi % BYTES) - 1 -: 8];
    end

    always_comb begin
        w_flat = int'(i_word_idx) * BYTES + int'(i_byte_idx);
        o_byte = '0;
        for (int k = 0; k < TOTAL; k++) begin
            if (w_flat == k) begin
                o_byte = w_bytes[k];
            end
        end
    end

endmodule

// File: rtl/led_byte_sequencer.sv
// Snapshots NUM_WORDS words on start and plays them out on the LED bus one byte per tick,
// MSB byte first, with an IDLE_PATTERN separator of GAP_SLOTS ticks between words.
module led_byte_sequencer
    import led_seq_pkg::*;
#(
    parameter int         NUM_WORDS    = 2,
    parameter int         WORD_W       = 128,
    parameter int         GAP_SLOTS    = 2,
    parameter logic [7:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN,
    localparam int        WI_W         = idx_width(NUM_WORDS),
    localparam int        BI_W         = idx_width(WORD_W / 8)
) (
    input  logic                        clk_divided,
    input  logic                        reset,
    input  logic [NUM_WORDS*WORD_W-1:0] words_in,
    input  logic                        start,
    input  logic                        mode_loop,
    input  logic                        hold,
    output logic [7:0]                  led,
    output logic                        busy,
    output logic                        done,
    output logic [WI_W-1:0]             word_idx,
    output logic [BI_W-1:0]             byte_idx
);

    localparam int                BYTES     = WORD_W / 8;
    localparam int                GAP_W     = idx_width(GAP_SLOTS + 1);
    localparam logic [WI_W-1:0]   LAST_WORD = WI_W'(NUM_WORDS - 1);
    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BYTES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_SLOTS > 0) ? GAP_SLOTS - 1 : 0);

    seq_state_t                  r_state;
    logic [NUM_WORDS*WORD_W-1:0] r_snapshot;
    logic [WI_W-1:0]             r_word_idx;
    logic [BI_W-1:0]             r_byte_idx;
    logic [GAP_W-1:0]            r_gap_cnt;
    logic [7:0]                  r_led;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_last_byte;
    logic                        w_last_word;
    logic [WI_W-1:0]             w_next_word;
    logic [WI_W-1:0]             w_sel_word;
    logic [BI_W-1:0]             w_sel_byte;
    logic [7:0]                  w_sel_led;

    // Indices that will be current after the next advancing tick; the LED register
    // loads the byte they point at so led and the indices always move together.
    // During GAP the indices already point at the upcoming word, byte 0.
    always_comb begin
        w_last_byte = (r_byte_idx == LAST_BYTE);
        w_last_word = (r_word_idx == LAST_WORD);
        w_next_word = w_last_word ? '0 : r_word_idx + 1'b1;
        w_sel_word  = r_word_idx;
        w_sel_byte  = '0;
        if (r_state == ST_SHOW) begin
            if (w_last_byte) begin
                w_sel_word = w_next_word;
            end else begin
                w_sel_byte = r_byte_idx + 1'b1;
            end
        end
    end

    word_byte_select #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W),
        .WI_W      (WI_W),
        .BI_W      (BI_W)
    ) u_select (
        .i_words    (r_snapshot),
        .i_word_idx (w_sel_word),
        .i_byte_idx (w_sel_byte),
        .o_byte     (w_sel_led)
    );

    // Priority: reset, then start low (abort / leave DONE), then hold, then normal playback.
    always_ff @(posedge clk_divided or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_snapshot <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_gap_cnt  <= '0;
            r_led      <= IDLE_PATTERN;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (!start) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_gap_cnt  <= '0;
            r_led      <= IDLE_PATTERN;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (!hold) begin
            case (r_state)
                ST_IDLE: begin
                    // First byte comes straight from the input since the snapshot loads on this same edge.
                    r_snapshot <= words_in;
                    r_state    <= ST_SHOW;
                    r_word_idx <= '0;
                    r_byte_idx <= '0;
                    r_gap_cnt  <= '0;
                    r_led      <= words_in[WORD_W-1 -: 8];
                    r_busy     <= 1'b1;
                end
                ST_SHOW: begin
                    if (!w_last_byte) begin
                        r_byte_idx <= w_sel_byte;
                        r_led      <= w_sel_led;
                    end else if (w_last_word && !mode_loop) begin
                        r_state    <= ST_DONE;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_led      <= IDLE_PATTERN;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_word_idx <= w_sel_word;
                        r_byte_idx <= '0;
                        if (GAP_SLOTS > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                            r_led     <= IDLE_PATTERN;
                        end else begin
                            r_led     <= w_sel_led;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_SHOW;
                        r_led   <= w_sel_led;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign led      = r_led;
    assign busy     = r_busy;
    assign done     = r_done;
    assign word_idx = r_word_idx;
    assign byte_idx = r_byte_idx;

endmodule
